// File: rtl/mdio_pkg.sv
// mdio_pkg: shared constants, state encoding and field helpers for the
// Clause 22 MDIO master.
package mdio_pkg;

   // Fixed two-bit frame fields, transmitted MSB first
   localparam logic [1:0] ST_BITS  = 2'b01;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] TA_WRITE = 2'b10;

   // Variable field widths
   localparam int PHY_W   = 5;
   localparam int REG_W   = 5;
   localparam int DATA_W  = 16;
   // ST + OP + PHY + REG + TA + DATA
   localparam int FRAME_W = 2 + 2 + PHY_W + REG_W + 2 + DATA_W;

   // One state per frame field; the state names the bit currently on the wire
   typedef enum logic [3:0] {
      IDLE,
      PRE,
      ST,
      OP,
      PHY,
      REG,
      TA,
      DATA,
      DONE
   } mdio_state_e;

   // Index of the last bit of a field (bit counter value that ends the field)
   function automatic logic [5:0] field_last(mdio_state_e s, int pre_len);
      logic [5:0] last;
      case (s)
         PRE:        last = 6'(pre_len - 1);
         ST, OP, TA: last = 6'd1;
         PHY:        last = 6'(PHY_W - 1);
         REG:        last = 6'(REG_W - 1);
         DATA:       last = 6'(DATA_W - 1);
         default:    last = 6'd0;
      endcase
      return last;
   endfunction

   // Position of a field's first bit inside the 32-bit post-preamble frame word
   function automatic logic [4:0] frame_base(mdio_state_e s);
      logic [4:0] base;
      case (s)
         OP:      base = 5'd2;
         PHY:     base = 5'd4;
         REG:     base = 5'd9;
         TA:      base = 5'd14;
         DATA:    base = 5'd16;
         default: base = 5'd0;
      endcase
      return base;
   endfunction

   // Field sequence of a frame; DONE closes it
   function automatic mdio_state_e next_field(mdio_state_e s);
      mdio_state_e nxt;
      case (s)
         PRE:     nxt = ST;
         ST:      nxt = OP;
         OP:      nxt = PHY;
         PHY:     nxt = REG;
         REG:     nxt = TA;
         TA:      nxt = DATA;
         DATA:    nxt = DONE;
         default: nxt = IDLE;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// mdio_clk_gen: MDC divider. Counts one bit period of 2*CLK_DIV clk cycles,
// low half first, and flags the clk edges where MDC rises and falls. Held in
// phase zero with MDC low whenever disabled, so every frame starts aligned.
module mdio_clk_gen #(
   parameter int CLK_DIV = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   output logic mdc_o,
   output logic fall_tick_o,
   output logic rise_tick_o
);

   localparam int PERIOD = 2 * CLK_DIV;
   localparam int CW     = $clog2(PERIOD);

   if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("mdio_clk_gen: CLK_DIV must be at least 2");
   end

   logic [CW-1:0] cnt_q, cnt_d;
   logic          mdc_q, mdc_d;

   // The tick outputs mark the clk edge at which MDC changes level
   assign rise_tick_o = en_i && (cnt_q == CW'(CLK_DIV - 1));
   assign fall_tick_o = en_i && (cnt_q == CW'(PERIOD - 1));
   assign mdc_o       = mdc_q;

   // Phase counter and MDC level; both collapse to zero when disabled
   always_comb begin
      cnt_d = '0;
      mdc_d = 1'b0;
      if (en_i) begin
         cnt_d = fall_tick_o ? '0 : cnt_q + CW'(1);
         if (rise_tick_o) begin
            mdc_d = 1'b1;
         end else if (fall_tick_o) begin
            mdc_d = 1'b0;
         end else begin
            mdc_d = mdc_q;
         end
      end
   end

   // Divider state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         mdc_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         mdc_q <= mdc_d;
      end
   end

endmodule

// File: rtl/mdio_master.sv
// mdio_master: IEEE 802.3 Clause 22 MDIO master. Runs one register read or
// write per accepted command, drives MDIO on MDC falling edges, samples it on
// MDC rising edges and reports read data plus a PHY-absent flag.
//
// Handshakes: a command transfers on the clk edge where cmd_valid && cmd_ready;
// cmd_valid is ignored while cmd_ready is low. rsp_valid is a single-cycle
// pulse with no back-pressure; rsp_rdata/rsp_err stay stable until the next one.
module mdio_master #(
   parameter int CLK_DIV      = 8,
   parameter int PREAMBLE_LEN = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [4:0]  cmd_phy,
   input  logic [4:0]  cmd_reg,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        busy,
   output logic        mdc,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        mdio_i
);

   import mdio_pkg::*;

   if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("mdio_master: CLK_DIV must be at least 2");
   end
   if (PREAMBLE_LEN < 0 || PREAMBLE_LEN > 32) begin : g_bad_preamble
      $error("mdio_master: PREAMBLE_LEN must be in 0..32");
   end

   mdio_state_e          state_q, state_d;
   logic [5:0]           bit_cnt_q, bit_cnt_d;
   logic [FRAME_W-1:0]   frame_q, frame_d;
   logic                 write_q, write_d;
   logic [DATA_W-1:0]    rdata_sh_q, rdata_sh_d;
   logic                 err_smp_q, err_smp_d;
   logic                 mdio_o_q, mdio_o_d;
   logic                 mdio_oe_q, mdio_oe_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
   logic                 rsp_err_q, rsp_err_d;
   logic [4:0]           frame_pos;
   logic                 accept;
   logic                 fall_tick;
   logic                 rise_tick;

   // The response cycle still counts as busy so a new command lands one cycle later
   assign cmd_ready = (state_q == IDLE) && !rsp_valid_q;
   assign busy      = (state_q != IDLE) || rsp_valid_q;
   assign accept    = cmd_valid && cmd_ready;

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign mdio_o    = mdio_o_q;
   assign mdio_oe   = mdio_oe_q;

   mdio_clk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_gen (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .en_i        (state_q != IDLE),
      .mdc_o       (mdc),
      .fall_tick_o (fall_tick),
      .rise_tick_o (rise_tick)
   );

   // FSM state register: current field and bit index within it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bit_cnt_q <= 6'd0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   // FSM next state: the handshake edge starts bit 0, every MDC fall advances a bit
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      if (state_q == IDLE) begin
         if (accept) begin
            state_d   = (PREAMBLE_LEN == 0) ? ST : PRE;
            bit_cnt_d = 6'd0;
         end
      end else if (fall_tick) begin
         if (bit_cnt_q == field_last(state_q, PREAMBLE_LEN)) begin
            state_d   = next_field(state_q);
            bit_cnt_d = 6'd0;
         end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
         end
      end
   end

   // FSM outputs: pad value/enable for the bit that starts on this edge
   always_comb begin
      mdio_o_d  = mdio_o_q;
      mdio_oe_d = mdio_oe_q;
      frame_pos = 5'd31 - (frame_base(state_d) + bit_cnt_d[4:0]);
      if (accept || fall_tick) begin
         mdio_o_d  = 1'b1;
         mdio_oe_d = 1'b0;
         case (state_d)
            PRE: begin
               mdio_oe_d = 1'b1;
            end
            ST, OP, PHY, REG: begin
               mdio_oe_d = 1'b1;
               mdio_o_d  = frame_d[frame_pos];
            end
            TA, DATA: begin
               // Reads release the line so the PHY can turn it around and drive data
               mdio_oe_d = write_d;
               mdio_o_d  = write_d ? frame_d[frame_pos] : 1'b1;
            end
            default: begin
               mdio_o_d  = 1'b1;
               mdio_oe_d = 1'b0;
            end
         endcase
      end
   end

   // Datapath: latch the command, sample TA/DATA on MDC rises, publish the response
   always_comb begin
      frame_d     = frame_q;
      write_d     = write_q;
      rdata_sh_d  = rdata_sh_q;
      err_smp_d   = err_smp_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      if (accept) begin
         write_d    = cmd_write;
         frame_d    = {ST_BITS, (cmd_write ? OP_WRITE : OP_READ), cmd_phy, cmd_reg,
                       TA_WRITE, cmd_wdata};
         rdata_sh_d = '0;
         err_smp_d  = 1'b0;
      end
      if (rise_tick && !write_q) begin
         // A driven PHY pulls the second TA bit low; a high level means nobody answered
         if (state_q == TA && bit_cnt_q == 6'd1) begin
            err_smp_d = mdio_i;
         end
         if (state_q == DATA) begin
            rdata_sh_d = {rdata_sh_q[DATA_W-2:0], mdio_i};
         end
      end
      if (fall_tick && state_q == DONE) begin
         rsp_valid_d = 1'b1;
         rsp_rdata_d = write_q ? '0 : rdata_sh_q;
         rsp_err_d   = write_q ? 1'b0 : err_smp_q;
      end
   end

   // Datapath and pad registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q     <= '0;
         write_q     <= 1'b0;
         rdata_sh_q  <= '0;
         err_smp_q   <= 1'b0;
         mdio_o_q    <= 1'b1;
         mdio_oe_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         frame_q     <= frame_d;
         write_q     <= write_d;
         rdata_sh_q  <= rdata_sh_d;
         err_smp_q   <= err_smp_d;
         mdio_o_q    <= mdio_o_d;
         mdio_oe_q   <= mdio_oe_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: directed scoreboard bench. Instance 0 uses the default
// parameters, instance 1 uses PREAMBLE_LEN=0 / CLK_DIV=2. Only one instance
// carries a frame at a time; 'cur' selects which one the monitor follows.
module tb_mdio_master;

   localparam int EW = 34; // {inst, err, latency[15:0], rdata[15:0]}

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        cmd_valid [2];
   logic        cmd_ready [2];
   logic        cmd_write [2];
   logic [4:0]  cmd_phy   [2];
   logic [4:0]  cmd_reg   [2];
   logic [15:0] cmd_wdata [2];
   logic        rsp_valid [2];
   logic [15:0] rsp_rdata [2];
   logic        rsp_err   [2];
   logic        busy      [2];
   logic        mdc       [2];
   logic        mdio_o    [2];
   logic        mdio_oe   [2];
   logic        mdio_i    [2];
   logic        phy_drive [2];
   logic        prev_mdc  [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      // Pad model: the line follows the master when enabled, else the PHY (pulled up)
      assign mdio_i[g] = mdio_oe[g] ? mdio_o[g] : phy_drive[g];

      mdio_master #(
         .CLK_DIV      (g == 0 ? 8 : 2),
         .PREAMBLE_LEN (g == 0 ? 32 : 0)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .cmd_valid (cmd_valid[g]),
         .cmd_ready (cmd_ready[g]),
         .cmd_write (cmd_write[g]),
         .cmd_phy   (cmd_phy[g]),
         .cmd_reg   (cmd_reg[g]),
         .cmd_wdata (cmd_wdata[g]),
         .rsp_valid (rsp_valid[g]),
         .rsp_rdata (rsp_rdata[g]),
         .rsp_err   (rsp_err[g]),
         .busy      (busy[g]),
         .mdc       (mdc[g]),
         .mdio_o    (mdio_o[g]),
         .mdio_oe   (mdio_oe[g]),
         .mdio_i    (mdio_i[g])
      );
   end

   // ---------------- bookkeeping ----------------
   logic [EW-1:0] exp_q[$];
   int          vectors     = 0;
   int          miscompares = 0;
   int          cyc         = 0;
   int          cur         = 0;
   int          hs_cyc      = 0;
   int          rsp_cyc_last = 0;
   int          last_hs_gap = 0;
   int          rdy_cnt     = 0;
   int          phy_idx     = 0;
   int          phy_mode    = 0;
   logic [15:0] phy_resp    = 16'h0000;
   logic [64:0] cap_o       = '0;
   logic [64:0] cap_oe      = '0;
   int          cap_n       = 0;
   int          rise1       = 0;
   int          rise2       = 0;

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // PHY model: mode 0 = no PHY (line floats high); mode 1 = answers with resp
   function automatic logic phy_bit(int idx, int pre, int mode, logic [15:0] resp);
      if (mode == 0) return 1'b1;
      if (idx == pre + 15) return 1'b0;
      if (idx >= pre + 16 && idx <= pre + 31) return resp[15 - (idx - pre - 16)];
      return 1'b1;
   endfunction

   // ---------------- clock / cycle count ----------------
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- monitor + scoreboard (samples on the falling edge) ----------------
   always @(negedge clk) begin
      logic [EW-1:0] e;
      // frame bookkeeping for the active instance
      if (cmd_valid[cur] && cmd_ready[cur]) begin
         hs_cyc      = cyc;
         last_hs_gap = cyc - rsp_cyc_last;
         rdy_cnt     = 0;
         cap_o       = '0;
         cap_oe      = '0;
         cap_n       = 0;
         phy_idx     = 0;
      end else if (cmd_ready[cur]) begin
         rdy_cnt++;
      end
      if (mdc[cur] && !prev_mdc[cur]) begin
         cap_o  = {cap_o[63:0], mdio_o[cur]};
         cap_oe = {cap_oe[63:0], mdio_oe[cur]};
         cap_n++;
         if (cap_n == 1) rise1 = cyc;
         if (cap_n == 2) rise2 = cyc;
      end
      if (!mdc[cur] && prev_mdc[cur]) phy_idx++;
      phy_drive[cur] = phy_bit(phy_idx, (cur == 0) ? 32 : 0, phy_mode, phy_resp);
      prev_mdc[0] = mdc[0];
      prev_mdc[1] = mdc[1];
      // response checking
      for (int g = 0; g < 2; g++) begin
         if (rsp_valid[g]) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL spurious_rsp: dut %0d rsp_valid with nothing expected", g);
            end else begin
               e = exp_q.pop_front();
               check("rsp_inst", 65'(g), 65'(e[33]));
               check("rsp_rdata", 65'(rsp_rdata[g]), 65'(e[15:0]));
               check("rsp_err", 65'(rsp_err[g]), 65'(e[32]));
               check("rsp_latency", 65'(cyc - hs_cyc), 65'(e[31:16]));
               check("ready_in_frame", 65'(rdy_cnt), 65'd0);
            end
            rsp_cyc_last = cyc;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Issue one command; caller is just after a rising edge
   task automatic send(input int g, input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                       input logic [15:0] wd, input int mode, input logic [15:0] resp,
                       input logic expect_rsp, input logic [15:0] exp_rd, input logic exp_err,
                       input int exp_lat, input logic keep_valid);
      int   t;
      logic hs;
      cur          = g;
      phy_mode     = mode;
      phy_resp     = resp;
      cmd_write[g] = wr;
      cmd_phy[g]   = phy;
      cmd_reg[g]   = rg;
      cmd_wdata[g] = wd;
      cmd_valid[g] = 1'b1;
      if (expect_rsp) exp_q.push_back({1'(g), exp_err, 16'(exp_lat), exp_rd});
      t = 0;
      do begin
         hs = cmd_ready[g];
         @(posedge clk);
         #1;
         t++;
      end while (!hs && t < 5000);
      if (!hs) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout: dut %0d never raised cmd_ready", g);
      end
      if (!keep_valid) cmd_valid[g] = 1'b0;
   endtask

   // Wait for every expected response, bounded
   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 5000) begin
         @(posedge clk);
         t++;
      end
      #1;
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL rsp_timeout: %0d responses outstanding", exp_q.size());
         exp_q.delete();
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int t;
      for (int g = 0; g < 2; g++) begin
         cmd_valid[g] = 1'b0;
         cmd_write[g] = 1'b0;
         cmd_phy[g]   = 5'h00;
         cmd_reg[g]   = 5'h00;
         cmd_wdata[g] = 16'h0000;
         phy_drive[g] = 1'b1;
         prev_mdc[g]  = 1'b0;
      end
      rst_n = 1'b0;
      tick(3);

      // reset values on both instances
      for (int g = 0; g < 2; g++) begin
         check("rst_mdc", 65'(mdc[g]), 65'd0);
         check("rst_mdio_o", 65'(mdio_o[g]), 65'd1);
         check("rst_mdio_oe", 65'(mdio_oe[g]), 65'd0);
         check("rst_cmd_ready", 65'(cmd_ready[g]), 65'd1);
         check("rst_busy", 65'(busy[g]), 65'd0);
         check("rst_rsp_valid", 65'(rsp_valid[g]), 65'd0);
         check("rst_rsp_rdata", 65'(rsp_rdata[g]), 65'd0);
         check("rst_rsp_err", 65'(rsp_err[g]), 65'd0);
      end
      rst_n = 1'b1;
      tick(2);

      // write PHY 0x10 REG 0x00 data 0x8140, defaults
      send(0, 1'b1, 5'h10, 5'h00, 16'h8140, 0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1041, 1'b0);
      drain();
      check("wr_bits", 65'(cap_o[64:1]), 65'({32'hFFFF_FFFF, 32'h5802_8140}));
      check("wr_oe", cap_oe, {64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
      check("wr_nbits", 65'(cap_n), 65'd65);
      tick(4);

      // read PHY 0x01 REG 0x02, PHY answers 0x0141
      send(0, 1'b0, 5'h01, 5'h02, 16'h0000, 1, 16'h0141, 1'b1, 16'h0141, 1'b0, 1041, 1'b0);
      drain();
      check("rd_header", 65'(cap_o[64:19]), 65'({32'hFFFF_FFFF, 14'h1822}));
      check("rd_oe", cap_oe, {{46{1'b1}}, {19{1'b0}}});
      tick(20);
      check("rd_hold", 65'(rsp_rdata[0]), 65'h0141);

      // read with no PHY present
      send(0, 1'b0, 5'h1F, 5'h01, 16'h0000, 0, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1041, 1'b0);
      drain();
      tick(4);

      // no preamble, CLK_DIV=2 write
      send(1, 1'b1, 5'h05, 5'h1F, 16'hA5C3, 0, 16'h0000, 1'b1, 16'h0000, 1'b0, 133, 1'b0);
      drain();
      check("fast_bits", 65'(cap_o[32:1]), 65'h52FE_A5C3);
      check("fast_oe", 65'(cap_oe[32:0]), 65'({32'hFFFF_FFFF, 1'b0}));
      check("fast_nbits", 65'(cap_n), 65'd33);
      check("fast_mdc_period", 65'(rise2 - rise1), 65'd4);
      tick(4);

      // back-to-back with cmd_valid held high
      send(0, 1'b1, 5'h02, 5'h04, 16'h1234, 0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1041, 1'b1);
      send(0, 1'b1, 5'h03, 5'h05, 16'h0BCD, 0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1041, 1'b0);
      check("b2b_accept_gap", 65'(last_hs_gap), 65'd1);
      drain();
      tick(4);

      // asynchronous reset during DATA bit 5, frame abandoned
      send(0, 1'b1, 5'h07, 5'h09, 16'hBEEF, 0, 16'h0000, 1'b0, 16'h0000, 1'b0, 0, 1'b0);
      t = 0;
      while (phy_idx != 53 && t < 3000) begin
         @(posedge clk);
         t++;
      end
      if (phy_idx != 53) begin
         vectors++;
         miscompares++;
         $display("FAIL data_bit5_timeout: bit index %0d", phy_idx);
      end
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("arst_mdc", 65'(mdc[0]), 65'd0);
      check("arst_mdio_oe", 65'(mdio_oe[0]), 65'd0);
      check("arst_mdio_o", 65'(mdio_o[0]), 65'd1);
      check("arst_busy", 65'(busy[0]), 65'd0);
      check("arst_cmd_ready", 65'(cmd_ready[0]), 65'd1);
      check("arst_rsp_valid", 65'(rsp_valid[0]), 65'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick(1100);

      // normal read after the abandoned frame
      send(0, 1'b0, 5'h03, 5'h04, 16'h0000, 1, 16'hC3A5, 1'b1, 16'hC3A5, 1'b0, 1041, 1'b0);
      drain();
      tick(4);

      check("queue_empty", 65'(exp_q.size()), 65'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mdio_master.md
# mdio_master

Parametrised IEEE 802.3 Clause 22 MDIO management master, the next-generation replacement for the fixed write-only PHY configuration sequencer. It accepts single register read or write commands over a valid/ready interface, generates MDC from the system clock via a programmable divider, drives and releases MDIO through separate output/enable/input pins, and returns read data with a PHY-absent error flag. A higher-level PHY init sequencer or CPU bridge sits upstream; the pad-level tristate buffer sits downstream.

## Interface
- CLK_DIV, 8: MDC half-period in clk cycles; values below 2 are illegal and fail elaboration.
- PREAMBLE_LEN, 32: number of preamble '1' bits, 0..32; 0 gives preamble suppression.
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; transfer on cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_phy  in  5  PHY address.
- cmd_reg  in  5  register address.
- cmd_wdata  in  16  write data, ignored for reads.
- rsp_valid  out  1  one-cycle pulse at end of every frame.
- rsp_rdata  out  16  read data, held until next rsp_valid; 0 after writes.
- rsp_err  out  1  valid with rsp_valid; 1 = read TA bit 2 sampled high.
- busy  out  1  high from accept until rsp_valid.
- mdc  out  1  management clock.
- mdio_o  out  1  MDIO output value.
- mdio_oe  out  1  MDIO output enable.
- mdio_i  in  1  MDIO input from pad.

## Operation
- States: IDLE, PRE, ST, OP, PHY, REG, TA, DATA, DONE.
- IDLE: mdc=0, mdio_oe=0, cmd_ready=1. On handshake, latch all cmd fields, go to PRE (or ST if PREAMBLE_LEN=0).
- PRE: PREAMBLE_LEN bits of '1'. ST: '0','1'. OP: write '0','1'; read '1','0'.
- PHY, REG: 5 bits each, MSB first.
- TA write: drive '1','0'. TA read: mdio_oe=0 for both bits; sample mdio_i at second TA bit, rsp_err = sampled value.
- DATA: 16 bits MSB first; write drives cmd_wdata, read keeps mdio_oe=0 and shifts mdio_i into a 16-bit register.
- DONE: one further bit period with mdio_oe=0 and mdc running, then rsp_valid pulse, return to IDLE.
- A 6-bit bit counter indexes bits within each state; it is reloaded on every state change.

## Timing
- Reset values: mdc=0, mdio_o=1, mdio_oe=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- One bit period = 2*CLK_DIV clk cycles: mdc low for CLK_DIV cycles, then high for CLK_DIV cycles.
- mdio_o/mdio_oe update only on the clk edge where mdc goes low (first cycle of each bit). mdio_i is sampled on the clk edge where mdc goes high.
- The first bit is driven on the cycle after the handshake; mdc stays 0 in IDLE.
- Frame length: PREAMBLE_LEN+32 bits plus 1 DONE bit; rsp_valid asserts 1 cycle after the DONE bit's high phase ends. Total latency is (PREAMBLE_LEN+33)*2*CLK_DIV+1 cycles from handshake; defaults give 1041.
- Back-to-back: cmd_ready returns the cycle after rsp_valid, and a new command may be accepted in that cycle.
- cmd_valid while busy is ignored; no queuing.
- Asynchronous reset mid-frame: all outputs return immediately to reset values, no rsp_valid, and the frame is abandoned.
- rsp_err=1 still returns the sampled (garbage) data; no retry.

## Structure
- Package mdio_pkg holds the ST/OP_WRITE/OP_READ/TA_WRITE 2-bit constants, the state enum, and the PHY/REG/DATA field widths.
- Sub-module mdio_clk_gen (param CLK_DIV) holds the divider counter and outputs mdc, fall_tick and rise_tick; it is enabled only while busy and resets its phase on enable.

## Test plan
- Write, PHY 0x10, REG 0x00, data 0x8140, defaults -> mdio_o sequence 32×'1',01,01,10000,00000,10,1000000101000000; rsp_valid after 1041 cycles; rsp_err=0.
- Read, PHY 0x01, REG 0x02, bench model drives TA '0' then 0x0141 -> rsp_rdata=0x0141, rsp_err=0; mdio_oe=0 from TA bit 1 through DONE.
- Read with no PHY (mdio_i pulled to 1) -> rsp_rdata=0xFFFF, rsp_err=1.
- PREAMBLE_LEN=0, CLK_DIV=2 write -> frame is exactly 32 bits, mdc period 4 cycles, latency 133 cycles.
- Two commands offered back-to-back with cmd_valid held high -> second accepted in the cycle after the first rsp_valid; cmd_ready=0 throughout the first frame.
- rst_n asserted during DATA bit 5 -> mdc=0, mdio_oe=0, busy=0 immediately; no rsp_valid; next command completes normally.
